mem_req_master: RTL

//  Initiator for the single-port word memory. Accepts tagged load/store requests

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_req_master_tag_fifo.sv | 61 ++++++
 rtl/mem_req_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths and request record for the word-memory initiator and the memory itself.
package mem_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_TAG_W   = 4;
  localparam int MEM_MAX_OUT = 4;

  typedef struct packed {
    logic                  is_store;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_req_t;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mem_req_master_tag_fifo.sv
// Synchronous tag FIFO: holds the tags of issued loads until their in-order responses return.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push  = i_push && !i_clear;
  assign w_pop   = i_pop && !i_clear && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_master.sv
// Load/store initiator for the single-port word memory: one-deep issue register,
// in-order tag matching of read responses, and squash-time dropping of in-flight loads.
module mem_req_master
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TAG_W   = MEM_TAG_W,
  parameter int MAX_OUT = MEM_MAX_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              resp_valid,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_resp,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              err_unexp
);

  localparam int CNT_W = cnt_w(MAX_OUT);
  localparam int SUM_W = CNT_W + 1;

  mem_req_t          r_iss;
  logic              r_iss_valid;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_resp_valid;
  logic [TAG_W-1:0]  r_resp_tag;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_err_unexp;

  logic              w_pend_load;
  logic [SUM_W-1:0]  w_outstanding;
  logic              w_accept;
  logic              w_issue_rd;
  logic              w_dropping;
  logic              w_resp_unexp;
  logic              w_resp_counted;
  logic              w_pop;
  logic              w_push;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [TAG_W-1:0]  w_fifo_head;

  // Loads being dropped still occupy memory slots, so they count toward the limit.
  assign w_pend_load   = r_iss_valid && !r_iss.is_store;
  assign w_outstanding = SUM_W'(r_inflight) + SUM_W'(r_drop_cnt) + SUM_W'(w_pend_load);
  assign req_ready     = !flush && (w_outstanding < SUM_W'(MAX_OUT));
  assign w_accept      = req_valid && req_ready;

  // A squash in the issue cycle cancels a registered load; stores are never cancelled.
  assign w_issue_rd   = w_pend_load && !flush;
  assign mem_rd_valid = w_issue_rd;
  assign mem_rd_addr  = r_iss.addr;
  assign mem_wr_valid = r_iss_valid && r_iss.is_store;
  assign mem_wr_addr  = r_iss.addr;
  assign mem_wr_data  = r_iss.wdata;

  assign w_dropping     = (r_drop_cnt != '0);
  assign w_resp_unexp   = mem_rd_resp && !w_dropping && w_fifo_empty;
  assign w_resp_counted = mem_rd_resp && !w_resp_unexp;
  assign w_pop          = mem_rd_resp && !w_dropping && !w_fifo_empty && !flush;
  assign w_push         = w_issue_rd && (!w_fifo_full || w_pop);

  assign resp_valid = r_resp_valid;
  assign resp_tag   = r_resp_tag;
  assign resp_data  = r_resp_data;
  assign err_unexp  = r_err_unexp;

  tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_iss.tag),
    .i_pop       (w_pop),
    .i_clear     (flush),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (w_fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss        <= '0;
      r_iss_valid  <= 1'b0;
      r_inflight   <= '0;
      r_drop_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
      r_err_unexp  <= 1'b0;
    end else begin
      r_iss_valid <= w_accept;
      if (w_accept) begin
        r_iss <= '{is_store: req_is_store, addr: req_addr, wdata: req_wdata, tag: req_tag};
      end

      r_resp_valid <= w_pop;
      if (w_pop) begin
        r_resp_tag  <= w_fifo_head;
        r_resp_data <= mem_rd_data;
      end

      if (w_resp_unexp) begin
        r_err_unexp <= 1'b1;
      end

      // Everything still owed by memory becomes a drop; a squash during dropping keeps the old debt.
      if (flush) begin
        r_inflight <= '0;
        r_drop_cnt <= r_drop_cnt + r_inflight - CNT_W'(w_resp_counted);
      end else begin
        if (w_push && !w_pop) begin
          r_inflight <= r_inflight + 1'b1;
        end else if (!w_push && w_pop) begin
          r_inflight <= r_inflight - 1'b1;
        end
        if (mem_rd_resp && w_dropping) begin
          r_drop_cnt <= r_drop_cnt - 1'b1;
        end
      end
    end
  end

endmodule
